// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared constants and state encoding for the alarm controller
// Purpose: state codes, sec_left width and default timing parameters.
// Ports: none (package).
package alarm_ctrl_pkg;

  localparam int SEC_LEFT_W      = 9;
  localparam int RING_SECS_DEF   = 60;
  localparam int SNOOZE_SECS_DEF = 300;
  localparam int MAX_SNOOZE_DEF  = 3;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_DISARMED = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_RINGING  = 3'd2;
  localparam logic [2:0] ST_SNOOZE   = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;

endpackage

// File: rtl/alarm_ctrl_key_edge.sv
// rtl/alarm_ctrl_key_edge.sv - rising-edge detector for a debounced front-panel key
// Purpose: one-cycle press pulse on the first cycle a key is seen high.
// Ports: clk_i, rst_i (async active-high), key_i (level), press_o (pulse).
module key_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  logic key_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_i;
    end
  end

  // Compared against the delayed copy, so a held key yields a single pulse.
  assign press_o = key_i & ~key_q;

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - ring / snooze / stop / auto-timeout sequencer for the alarm
// Purpose: FSM plus per-interval seconds counter driving buzzer and display status.
// Ports: clk, rst (async active-high), tick_1hz, alarm_en, alarm_match, stop_key,
//        snooze_key in; buzzer, ringing, snoozing, snooze_cnt, sec_left, state out.
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_SECS   = RING_SECS_DEF,
  parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
  parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF,
  localparam int CNT_W      = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic                  alarm_en,
  input  logic                  alarm_match,
  input  logic                  stop_key,
  input  logic                  snooze_key,
  output logic                  buzzer,
  output logic                  ringing,
  output logic                  snoozing,
  output logic [CNT_W-1:0]      snooze_cnt,
  output logic [SEC_LEFT_W-1:0] sec_left,
  output logic [2:0]            state
);

  if (RING_SECS < 2 || RING_SECS > 511 || SNOOZE_SECS < 2 || SNOOZE_SECS > 511 ||
      MAX_SNOOZE < 0 || MAX_SNOOZE > 511) begin : g_bad_param
    $error("alarm_ctrl: timing parameter out of range");
  end

  localparam logic [SEC_LEFT_W-1:0] RING_LOAD   = SEC_LEFT_W'(RING_SECS);
  localparam logic [SEC_LEFT_W-1:0] SNOOZE_LOAD = SEC_LEFT_W'(SNOOZE_SECS);
  localparam logic [SEC_LEFT_W-1:0] SEC_ONE     = SEC_LEFT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX     = CNT_W'(MAX_SNOOZE);

  state_t                  state_q, state_d;
  logic [SEC_LEFT_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    beep_q, beep_d;
  logic                    stop_press, snooze_press;

  key_edge u_stop_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .key_i   (stop_key),
    .press_o (stop_press)
  );

  key_edge u_snooze_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .key_i   (snooze_key),
    .press_o (snooze_press)
  );

  // Branch order encodes the priority: disable, stop, snooze, then tick.
  // A key that changes the state consumes the cycle, so a coincident tick
  // never lands on the freshly loaded interval.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
    case (state_q)
      ST_DISARMED: begin
        if (alarm_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!alarm_en) begin
          state_d = ST_DISARMED;
        end else if (alarm_match) begin
          state_d = ST_RINGING;
          sec_d   = RING_LOAD;
          cnt_d   = '0;
          beep_d  = 1'b0;
        end
      end
      ST_RINGING: begin
        if (!alarm_en) begin
          state_d = ST_DISARMED;
          sec_d   = '0;
        end else if (stop_press) begin
          state_d = ST_HOLD;
          sec_d   = '0;
        end else if (snooze_press) begin
          if (cnt_q == CNT_MAX) begin
            state_d = ST_HOLD;
            sec_d   = '0;
          end else begin
            state_d = ST_SNOOZE;
            sec_d   = SNOOZE_LOAD;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (tick_1hz) begin
          if (sec_q == SEC_ONE) begin
            state_d = ST_HOLD;
            sec_d   = '0;
          end else begin
            sec_d  = sec_q - 1'b1;
            beep_d = ~beep_q;
          end
        end
      end
      ST_SNOOZE: begin
        if (!alarm_en) begin
          state_d = ST_DISARMED;
          sec_d   = '0;
        end else if (stop_press) begin
          state_d = ST_HOLD;
          sec_d   = '0;
        end else if (tick_1hz) begin
          // Expiry rings directly, even if the match minute has passed.
          if (sec_q == SEC_ONE) begin
            state_d = ST_RINGING;
            sec_d   = RING_LOAD;
            beep_d  = 1'b0;
          end else begin
            sec_d = sec_q - 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Waits out the matching minute so the same match cannot re-trigger.
        if (!alarm_en) begin
          state_d = ST_DISARMED;
        end else if (!alarm_match) begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
        sec_d   = '0;
      end
    endcase
    if (state_d != ST_RINGING) beep_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DISARMED;
      sec_q   <= '0;
      cnt_q   <= '0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      beep_q  <= beep_d;
    end
  end

  assign ringing    = (state_q == ST_RINGING);
  assign snoozing   = (state_q == ST_SNOOZE);
  assign buzzer     = ringing & beep_q;
  assign snooze_cnt = cnt_q;
  assign sec_left   = sec_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed self-checking bench for alarm_ctrl
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, alarm_en, alarm_match, stop_key, snooze_key;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;
  logic [8:0] sec_left;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  alarm_ctrl #(.RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .alarm_en    (alarm_en),
    .alarm_match (alarm_match),
    .stop_key    (stop_key),
    .snooze_key  (snooze_key),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_cnt  (snooze_cnt),
    .sec_left    (sec_left),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Nine quiet clocks then a one-clock tick: one second at 10 clks per tick.
  task automatic second();
    repeat (9) step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0; alarm_match = 1'b0;
    stop_key = 1'b0; snooze_key = 1'b0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_sec", sec_left, 0);
    chk("rst_cnt", snooze_cnt, 0);
    rst = 1'b0;
    alarm_en = 1'b1;
    step();
    chk("arm", state, 1);

    // 1. ring and auto-timeout
    alarm_match = 1'b1; step();
    chk("s1_ring", state, 2);
    chk("s1_sec4", sec_left, 4);
    chk("s1_bz0", buzzer, 0);
    chk("s1_ringing", ringing, 1);
    second(); chk("s1_t1_bz", buzzer, 1); chk("s1_t1_sec", sec_left, 3);
    second(); chk("s1_t2_bz", buzzer, 0);
    second(); chk("s1_t3_bz", buzzer, 1);
    second(); chk("s1_t4_hold", state, 4); chk("s1_t4_bz", buzzer, 0);
    chk("s1_t4_sec", sec_left, 0);
    step(); chk("s1_hold_stays", state, 4);
    alarm_match = 1'b0; step();
    chk("s1_rearm", state, 1);

    // 2. snooze cycle up to the limit
    alarm_match = 1'b1; step();
    chk("s2_ring", state, 2); chk("s2_cnt0", snooze_cnt, 0);
    snooze_key = 1'b1; step(); snooze_key = 1'b0;
    chk("s2_snz", state, 3); chk("s2_cnt1", snooze_cnt, 1); chk("s2_sec3", sec_left, 3);
    chk("s2_snoozing", snoozing, 1);
    alarm_match = 1'b0;
    step();
    second(); chk("s2_sec2", sec_left, 2);
    second(); second();
    chk("s2_rering", state, 2); chk("s2_rering_sec", sec_left, 4);
    snooze_key = 1'b1; step(); snooze_key = 1'b0;
    chk("s2_cnt2", snooze_cnt, 2); chk("s2_snz2", state, 3);
    step();
    second(); second(); second();
    chk("s2_rering2", state, 2);
    snooze_key = 1'b1; step(); snooze_key = 1'b0;
    chk("s2_limit_hold", state, 4); chk("s2_limit_cnt", snooze_cnt, 2);
    step();
    chk("s2_rearm", state, 1);

    // 3. stop during snooze
    alarm_match = 1'b1; step();
    snooze_key = 1'b1; step(); snooze_key = 1'b0;
    chk("s3_snz", state, 3); chk("s3_bz_a", buzzer, 0);
    step();
    stop_key = 1'b1; step(); stop_key = 1'b0;
    chk("s3_hold", state, 4); chk("s3_bz_b", buzzer, 0);
    step(); chk("s3_hold2", state, 4); chk("s3_bz_c", buzzer, 0);
    alarm_match = 1'b0; step();
    chk("s3_rearm", state, 1); chk("s3_bz_d", buzzer, 0);

    // 4. simultaneous events
    alarm_match = 1'b1; step();
    snooze_key = 1'b1; step(); snooze_key = 1'b0;
    step();
    second(); second(); second();
    chk("s4_ring_cnt1", snooze_cnt, 1); chk("s4_ring", state, 2);
    repeat (9) step();
    stop_key = 1'b1; snooze_key = 1'b1; tick_1hz = 1'b1; step();
    stop_key = 1'b0; snooze_key = 1'b0; tick_1hz = 1'b0;
    chk("s4_both_hold", state, 4); chk("s4_both_cnt", snooze_cnt, 1);
    alarm_match = 1'b0; step();
    alarm_match = 1'b1; step();
    chk("s4_ring2", state, 2);
    second(); chk("s4_sec3", sec_left, 3);
    repeat (9) step();
    snooze_key = 1'b1; tick_1hz = 1'b1; step();
    snooze_key = 1'b0; tick_1hz = 1'b0;
    chk("s4_snz_tick_state", state, 3); chk("s4_snz_tick_sec", sec_left, 3);

    // 5. held snooze key: one event only, even across the return to RINGING
    stop_key = 1'b1; step(); stop_key = 1'b0;
    alarm_match = 1'b0; step();
    alarm_match = 1'b1; step();
    chk("s5_ring", state, 2);
    snooze_key = 1'b1; step();
    chk("s5_snz", state, 3);
    for (int i = 1; i < 50; i++) begin
      tick_1hz = (i % 10 == 0);
      step();
    end
    tick_1hz = 1'b0;
    chk("s5_state", state, 2); chk("s5_cnt", snooze_cnt, 1); chk("s5_sec", sec_left, 3);
    chk("s5_bz", buzzer, 1);
    snooze_key = 1'b0; step();
    chk("s5_release_state", state, 2); chk("s5_release_cnt", snooze_cnt, 1);

    // 6. disable and async reset mid-operation
    alarm_en = 1'b0; step();
    chk("s6_dis", state, 0); chk("s6_dis_bz", buzzer, 0);
    alarm_en = 1'b1; step();
    step();
    chk("s6_ring", state, 2);
    snooze_key = 1'b1; step(); snooze_key = 1'b0;
    chk("s6_snz", state, 3);
    step();
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_state", state, 0); chk("s6_rst_snoozing", snoozing, 0);
    chk("s6_rst_sec", sec_left, 0); chk("s6_rst_cnt", snooze_cnt, 0);
    step(); step();
    rst = 1'b0;
    #1 chk("s6_after_rel", state, 0);
    step();
    chk("s6_arm", state, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Sequencing controller for the alarm datapath. It consumes the minute/hour match flag produced by the alarm-time comparator and the 1 Hz second tick, and runs the ring / snooze / stop / auto-timeout policy. It drives the buzzer and the status outputs for the display. It sits between the alarm comparator, the front-panel keys and the buzzer pin.

Parameters:
RING_SECS, 60, seconds of ringing before auto-timeout (>=2)
SNOOZE_SECS, 300, snooze interval in seconds (>=2)
MAX_SNOOZE, 3, snoozes allowed per alarm event; after that, snooze acts as stop

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-clk pulse per second, synchronous to clk
alarm_en  in  1  level; alarm armed when 1
alarm_match  in  1  level; 1 while alarm hour/min equals clock hour/min (stays high for the whole matching minute)
stop_key  in  1  level key, already debounced
snooze_key  in  1  level key, already debounced
buzzer  out  1  buzzer drive
ringing  out  1  1 in RINGING
snoozing  out  1  1 in SNOOZE
snooze_cnt  out  2  snoozes used in the current event (width ceil(log2(MAX_SNOOZE+1)), 2 at default)
sec_left  out  9  seconds remaining in the current RINGING/SNOOZE interval; 0 elsewhere
state  out  3  state code (package encoding)

Behaviour:
- Reset (async, rst=1): state=DISARMED; all outputs 0; internal counters 0; key edge registers 0.
- Key presses are rising edges of stop_key/snooze_key, detected against a 1-cycle delayed copy. Holding a key produces exactly one event.
- All transitions are registered. Outputs change on the clk edge after the causing input.
- States and transitions:
  - DISARMED: alarm_en=1 -> ARMED.
  - ARMED: alarm_en=0 -> DISARMED. Otherwise alarm_match=1 -> RINGING, with sec_left=RING_SECS and snooze_cnt=0. Enabling during a matching minute rings immediately.
  - RINGING:
    - Priority order: alarm_en=0 > stop press > snooze press > timeout.
    - alarm_en=0 -> DISARMED.
    - Stop press -> HOLD.
    - Snooze press -> if snooze_cnt==MAX_SNOOZE, go to HOLD. Otherwise go to SNOOZE, with snooze_cnt+1 and sec_left=SNOOZE_SECS.
    - On tick_1hz, sec_left decrements. A tick with sec_left==1 -> HOLD (auto-timeout).
  - SNOOZE:
    - alarm_en=0 -> DISARMED.
    - Stop press -> HOLD (cancels the event).
    - Snooze press is ignored.
    - On tick_1hz, sec_left decrements. A tick with sec_left==1 -> RINGING, with sec_left=RING_SECS and snooze_cnt kept.
  - HOLD:
    - alarm_en=0 -> DISARMED.
    - alarm_match=0 -> ARMED.
    - Prevents re-trigger within the same minute.
    - SNOOZE does not pass through HOLD when it expires; a snooze may land outside the match minute and still ring.
- Simultaneous events in the same cycle: a key press and a tick both arrive -> the key wins, and the tick is not applied to the new interval. Stop and snooze pressed together -> stop.
- buzzer = ringing & beep_phase. beep_phase clears on RINGING entry and toggles on each tick_1hz while RINGING, giving 1 s on / 1 s off starting with a silent first second. beep_phase is forced to 0 outside RINGING. buzzer is 0 in every other state.
- ringing, snoozing and state are pure decodes of the state register. sec_left is a register.
- sec_left width is fixed at 9 (max 511). Parameters above 511 are illegal; enforce with an elaboration-time check.
- alarm_en drop mid-RINGING silences the buzzer on the next clk edge.

Decomposition:
- Package alarm_ctrl_pkg:
  - state encoding: DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3, HOLD=4
  - SEC_LEFT_W=9
  - default values for RING_SECS, SNOOZE_SECS, MAX_SNOOZE
- Sub-module key_edge: one per key; registered rising-edge detector with async active-high reset. Everything else lives in alarm_ctrl (FSM plus interval counter, roughly 150-200 lines).

Test Plan:
All scenarios use RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2, and a tick every 10 clks.
1. Basic ring and timeout:
   - Stimulus: en=1, raise match.
   - Response: next clk state=2, sec_left=4, buzzer=0. After the 1st tick buzzer=1, after the 2nd tick 0. After the 4th tick state=4, buzzer=0. Drop match -> state=1.
2. Snooze cycle:
   - Stimulus: ring, then press snooze.
   - Response: state=3, snooze_cnt=1, sec_left=3. After 3 ticks state=2, sec_left=4, with match already dropped. A 2nd snooze gives snooze_cnt=2. A 3rd snooze press in RINGING -> state=4.
3. Stop during snooze:
   - Stimulus: stop press while in SNOOZE.
   - Response: state=4 (HOLD) while match=1; state=1 after match drops. Check buzzer=0 throughout.
4. Simultaneous events:
   - Stimulus: stop and snooze pressed together in RINGING, with a tick in the same cycle.
   - Response: state=4, snooze_cnt unchanged.
   - Stimulus: snooze pressed in the same cycle as a tick.
   - Response: sec_left=3, not 2.
5. Key hold:
   - Stimulus: hold snooze_key high for 50 clks in RINGING.
   - Response: exactly one snooze (snooze_cnt=1). No action on release.
6. Disable and reset mid-operation:
   - Stimulus: drop alarm_en in RINGING.
   - Response: next clk state=0, buzzer=0.
   - Stimulus: assert rst mid-SNOOZE, between clk edges.
   - Response: outputs 0 immediately; after release state=0 (DISARMED), then ARMED on the next clk since alarm_en=1.
